// File: rtl/scan_load_capture_ctrl.sv
// Scan-chain controller: serially loads PPIs into an N-bit chain, captures PPOs back
// for LSB-first unload, and behaves as the core's plain state register in functional mode.
module scan_load_capture_ctrl #(
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test_mode,
    input  logic             start,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic [N-1:0]     ppo,
    output logic [N-1:0]     ppi,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pat_cnt
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [N-1:0]     r_chain, w_chain_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_pat_cnt, w_pat_cnt_nxt;

    // Serial bit enters at the MSB end so the first bit loaded finishes in chain[0].
    function automatic logic [N-1:0] shift_in(input logic [N-1:0] c, input logic b);
        logic [N-1:0] res;
        res        = c >> 1;
        res[N-1]   = b;
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_chain   <= '0;
            r_cnt     <= '0;
            r_pat_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_chain   <= w_chain_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pat_cnt <= w_pat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_chain_nxt   = r_chain;
        w_cnt_nxt     = r_cnt;
        w_pat_cnt_nxt = r_pat_cnt;
        if (!test_mode) begin
            // Functional mode overrides any scan operation in flight.
            w_state_nxt = S_IDLE;
            w_chain_nxt = ppo;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_SHIFT;
                        w_cnt_nxt   = '0;
                    end
                end
                S_SHIFT: begin
                    w_chain_nxt = shift_in(r_chain, scan_in);
                    if (r_cnt == LAST_SHIFT) begin
                        w_state_nxt = S_CAPTURE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
                S_CAPTURE: begin
                    w_chain_nxt   = ppo;
                    w_pat_cnt_nxt = r_pat_cnt + CNT_W'(1);
                    w_state_nxt   = S_DONE;
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign ppi      = r_chain;
    assign scan_out = r_chain[0];
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign pat_cnt  = r_pat_cnt;

endmodule

// File: tb/tb_scan_load_capture_ctrl.sv
// Directed bench for scan_load_capture_ctrl: an 8-bit-counter instance and a 2-bit-counter
// instance share stimulus; expected unload bits and pattern results go through queues.
module tb_scan_load_capture_ctrl;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         test_mode;
    logic         start;
    logic         scan_in;
    logic [N-1:0] ppo;

    logic         so1, busy1, done1;
    logic [N-1:0] ppi1;
    logic [7:0]   pat1;
    logic         so2, busy2, done2;
    logic [N-1:0] ppi2;
    logic [1:0]   pat2;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_chain;
    int           m_pat;

    typedef struct packed {
        logic [N-1:0] ld;
        logic [N-1:0] cap;
        logic [7:0]   pat;
    } exp_t;

    exp_t res_q[$];
    logic so_q[$];

    scan_load_capture_ctrl #(.N(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .test_mode(test_mode), .start(start), .scan_in(scan_in),
        .scan_out(so1), .ppo(ppo), .ppi(ppi1), .busy(busy1), .done(done1), .pat_cnt(pat1)
    );

    scan_load_capture_ctrl #(.N(N), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .test_mode(test_mode), .start(start), .scan_in(scan_in),
        .scan_out(so2), .ppo(ppo), .ppi(ppi2), .busy(busy2), .done(done2), .pat_cnt(pat2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_cnt(input string tag);
        logic [31:0] p;
        p = m_pat;
        chk({tag, "_pat8"}, 32'(pat1), p & 32'hFF);
        chk({tag, "_pat2"}, 32'(pat2), p & 32'h3);
    endtask

    // bits[0] is shifted first and must land in ppi[0]; poke pulses start while busy.
    task automatic run_pattern(input logic [1:0] bits, input logic [1:0] pv, input bit poke);
        exp_t e;
        so_q.push_back(m_chain[0]);
        so_q.push_back(m_chain[1]);
        m_pat = m_pat + 1;
        e.ld  = bits;
        e.cap = pv;
        e.pat = 8'(m_pat);
        res_q.push_back(e);
        m_chain = pv;

        test_mode = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_shift", 32'(busy1), 32'd1);
        scan_in = bits[0];
        chk("unload_bit0", 32'(so1), 32'(so_q.pop_front()));
        tick();
        if (poke) start = 1'b1;
        scan_in = bits[1];
        chk("unload_bit1", 32'(so1), 32'(so_q.pop_front()));
        tick();
        start   = 1'b0;
        scan_in = 1'b0;
        e = res_q.pop_front();
        chk("ppi_loaded", 32'(ppi1), 32'(e.ld));
        chk("done_low_capture", 32'(done1), 32'd0);
        chk("busy_capture", 32'(busy1), 32'd1);
        ppo = pv;
        tick();
        ppo = ~pv;
        chk("done_pulse", 32'(done1), 32'd1);
        chk("chain_captured", 32'(ppi1), 32'(e.cap));
        chk("pat8_after_cap", 32'(pat1), 32'(e.pat));
        chk("pat2_after_cap", 32'(pat2), 32'(e.pat[1:0]));
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_one_cycle", 32'(done1), 32'd0);
        chk("idle_after_done", 32'(busy1), 32'd0);
        if (poke) begin
            tick();
            chk("no_extra_pattern", 32'(busy1), 32'd0);
            chk_idle_cnt("poke");
        end
        chk("chain_holds_idle", 32'(ppi1), 32'(m_chain));
    endtask

    initial begin
        rst       = 1'b1;
        test_mode = 1'b0;
        start     = 1'b0;
        scan_in   = 1'b0;
        ppo       = '0;
        m_chain   = '0;
        m_pat     = 0;
        #1;
        chk("rst_ppi", 32'(ppi1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        repeat (2) tick();
        rst = 1'b0;

        // Functional load, then asynchronous reset between edges.
        ppo = 2'b11;
        tick();
        chk("func_ppi_pre_rst", 32'(ppi1), 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ppi", 32'(ppi1), 32'd0);
        chk("async_rst_so", 32'(so1), 32'd0);
        chk("async_rst_busy", 32'(busy1), 32'd0);
        chk("async_rst_done", 32'(done1), 32'd0);
        chk("async_rst_pat", 32'(pat1), 32'd0);
        tick();
        rst       = 1'b0;
        ppo       = 2'b00;
        test_mode = 1'b1;
        tick();
        m_chain = '0;

        run_pattern(2'b01, 2'b10, 1'b0);
        run_pattern(2'b10, 2'b01, 1'b0);
        run_pattern(2'b11, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            run_pattern(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
        end

        // Functional mode load.
        test_mode = 1'b0;
        ppo       = 2'b11;
        tick();
        m_chain = 2'b11;
        chk("func_ppi", 32'(ppi1), 32'h3);
        chk("func_busy", 32'(busy1), 32'd0);
        chk_idle_cnt("func");

        // Abort mid-SHIFT by dropping test_mode.
        test_mode = 1'b1;
        ppo       = 2'b00;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        scan_in = 1'b0;
        tick();
        chk("abort_busy_pre", 32'(busy1), 32'd1);
        test_mode = 1'b0;
        ppo       = 2'b01;
        tick();
        m_chain = 2'b01;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_done", 32'(done1), 32'd0);
        chk("abort_ppi", 32'(ppi1), 32'h1);
        chk_idle_cnt("abort");
        test_mode = 1'b1;
        tick();
        chk("abort_no_done_later", 32'(done1), 32'd0);

        run_pattern(2'b10, 2'b11, 1'b0);

        // Reset mid-SHIFT clears everything with no done pulse.
        start = 1'b1;
        tick();
        start   = 1'b0;
        scan_in = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_ppi", 32'(ppi1), 32'd0);
        chk("midrst_pat8", 32'(pat1), 32'd0);
        chk("midrst_pat2", 32'(pat2), 32'd0);
        tick();
        rst     = 1'b0;
        scan_in = 1'b0;
        m_chain = '0;
        m_pat   = 0;
        repeat (2) begin
            tick();
            chk("midrst_no_done", 32'(done1), 32'd0);
        end

        run_pattern(2'b01, 2'b01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scan_load_capture_ctrl.md
Name: scan_load_capture_ctrl

Overview:
- Scan-chain controller that sits directly upstream and downstream of the sequential-to-combinational test core.
- Serially loads pseudo-primary-input (PPI) values into an N-bit scan chain and drives them to the core as its flop-state inputs (ppi[0] feeds qB, ppi[1] feeds qC for N=2).
- Captures the core's pseudo-primary outputs (PPOs) back into the chain for serial unload.
- In functional mode the chain acts as the core's ordinary state register.

Parameters:
- N, 2, scan chain length = number of cut flops (PPI/PPO width); legal range 1..32.
- CNT_W, 8, width of the pattern counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- test_mode  input  1  1 = scan test operation; 0 = functional mode.
- start  input  1  one-cycle request to run one load/capture pattern; sampled only in IDLE.
- scan_in  input  1  serial scan data in.
- scan_out  output  1  serial scan data out, always equal to chain[0].
- ppo  input  N  pseudo-primary outputs from the combinational core (next-state values B, C).
- ppi  output  N  pseudo-primary inputs to the core; equals the chain register.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse while in DONE.
- pat_cnt  output  CNT_W  number of completed captures.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, chain=0, shift count=0, pat_cnt=0.
  - Outputs ppi=0, scan_out=0, busy=0, done=0.
  - Reset asserted mid-operation aborts immediately; no capture occurs and pat_cnt is not incremented.
- States: IDLE, SHIFT, CAPTURE, DONE.
- IDLE:
  - Edge with test_mode=1 and start=1: go to SHIFT, shift count = 0.
  - Otherwise stay. Chain holds when test_mode=1 and no start.
- SHIFT:
  - Each edge: chain <= {scan_in, chain[N-1:1]}; count increments.
  - At the edge where count==N-1, go to CAPTURE.
  - Exactly N shift edges occur. The first serial bit ends in chain[0]; the last ends in chain[N-1].
  - Old chain contents leave on scan_out LSB-first, so the previous pattern unloads while the next one loads.
- CAPTURE:
  - One edge: chain <= ppo; pat_cnt <= pat_cnt+1 (wraps from all-ones to 0); go to DONE.
  - ppi is stable for the whole CAPTURE cycle; the core output is purely combinational.
- DONE:
  - done=1 for exactly one cycle; next edge goes to IDLE.
  - A start seen in DONE is ignored.
- Latency: start sampled at edge E0 → shifts at E1..EN → capture at EN+1 → done high between EN+1 and EN+2 → idle from EN+2. Total N+2 cycles.
- start while busy: ignored; no queuing.
- Functional mode (test_mode=0):
  - Every edge: chain <= ppo; state forced to IDLE; count cleared; pat_cnt holds; start ignored.
  - Dropping test_mode mid-SHIFT or mid-CAPTURE aborts to IDLE on the next edge, with the functional load and no done pulse.
- scan_in is sampled only in SHIFT. ppo is sampled only in CAPTURE or in functional mode.
- N=1: SHIFT lasts one edge; the same rules apply.

Test Plan:
- Reset: assert rst asynchronously between edges → ppi=00, scan_out=0, busy=0, done=0, pat_cnt=0 immediately.
- Load (N=2): start, scan_in=1 then 0 on the two SHIFT edges → ppi=2'b01 (qB=1, qC=0). With ppo=2'b10 at CAPTURE → chain=2'b10, pat_cnt=1, done high exactly one cycle, 4 cycles after start edge.
- Unload/overlap: after the previous case, start again with scan_in=0 then 1 → scan_out shows 0 then 1 during SHIFT (captured 10 unloaded LSB-first). New ppi=2'b10, i.e. qB=0, qC=1.
- Busy/ignore: pulse start during SHIFT and during DONE → no extra pattern, pat_cnt advances by only 1.
- Functional and abort: test_mode=0 with ppo=2'b11 → ppi=11 next edge, busy=0. Drop test_mode mid-SHIFT → IDLE next edge, chain=ppo, no done, pat_cnt unchanged.
- Counter wrap: CNT_W=2, run 4 patterns → pat_cnt 1,2,3,0. Reset mid-SHIFT → all state cleared, no done.
